// File: rtl/ccff_loader_pkg.sv
// Shared types for the configuration-chain loader: FSM state encoding and a
// helper giving the start-to-done cycle count of one load.
package ccff_loader_pkg;

  localparam int unsigned STATE_W = 2;

  typedef enum logic [STATE_W-1:0] {
    IDLE  = 2'd0,
    LOAD  = 2'd1,
    SHIFT = 2'd2,
    DONE  = 2'd3
  } ccff_state_e;

  // Cycles from the start cycle to the done cycle with s_valid held high.
  function automatic int unsigned load_cycles(input int unsigned chain_len,
                                              input int unsigned word_w);
    return chain_len + (chain_len + word_w - 1) / word_w + 1;
  endfunction

endpackage

// File: rtl/ccff_piso_shifter.sv
// Parallel-in/serial-out word register, MSB first, tracking how many bits of
// the current word are still to be shifted.
module ccff_piso_shifter #(
  parameter int unsigned WORD_W = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              load,
  input  logic              shift,
  input  logic [WORD_W-1:0] data,
  output logic              next_msb_c,
  output logic              empty,
  output logic              last_c
);

  localparam int unsigned WB_W = $clog2(WORD_W + 1);

  logic [WORD_W-1:0] sreg;
  logic [WORD_W-1:0] sreg_shl;
  logic [WB_W-1:0]   word_bits;

  assign sreg_shl = sreg << 1;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sreg      <= '0;
      word_bits <= '0;
    end else if (load) begin
      sreg      <= data;
      word_bits <= WB_W'(WORD_W);
    end else if (shift && !empty) begin
      sreg      <= sreg_shl;
      word_bits <= word_bits - WB_W'(1);
    end
  end

  // Bit presented after the next shift; lets the caller register ccff_head.
  assign next_msb_c = sreg_shl[WORD_W-1];
  assign empty      = (word_bits == '0);
  assign last_c     = (word_bits == WB_W'(1));

endmodule

// File: rtl/ccff_bitstream_loader.sv
// Serialises host configuration words onto the ccff chain head for exactly
// CHAIN_LEN shift cycles. Optional readback of the old chain: CCFF_READBACK_EN.
module ccff_bitstream_loader
  import ccff_loader_pkg::*;
#(
  parameter int unsigned CHAIN_LEN = 8,
  parameter int unsigned WORD_W    = 8
) (
  input  logic              prog_clk,
  input  logic              prog_rst_n,
  input  logic              start,
  input  logic [WORD_W-1:0] s_data,
  input  logic              s_valid,
  output logic              s_ready,
  output logic              ccff_head,
  output logic              ccff_shift_en,
  output logic              busy,
  output logic              done
`ifdef CCFF_READBACK_EN
  ,
  input  logic              ccff_tail,
  output logic [WORD_W-1:0] m_data,
  output logic              m_valid
`endif
);

  localparam int unsigned CNT_W = $clog2(CHAIN_LEN + 1);

  ccff_state_e      state;
  ccff_state_e      next_state;
  logic [CNT_W-1:0] bit_cnt;
  logic             accept_c;
  logic             shift_c;
  logic             last_bit_c;
  logic             word_last_c;
  logic             word_empty_c;
  logic             next_msb_c;
  logic             head_d;

  assign accept_c   = (state == LOAD) && s_valid;
  assign shift_c    = (state == SHIFT) && !word_empty_c;
  assign last_bit_c = (bit_cnt == CNT_W'(CHAIN_LEN - 1));

  ccff_piso_shifter #(
    .WORD_W (WORD_W)
  ) u_piso (
    .clk        (prog_clk),
    .rst_n      (prog_rst_n),
    .load       (accept_c),
    .shift      (shift_c),
    .data       (s_data),
    .next_msb_c (next_msb_c),
    .empty      (word_empty_c),
    .last_c     (word_last_c)
  );

  // Next state and the head bit to present during the following cycle.
  always_comb begin
    next_state = state;
    head_d     = 1'b0;
    case (state)
      IDLE: if (start) next_state = LOAD;
      LOAD: begin
        if (s_valid) begin
          next_state = SHIFT;
          head_d     = s_data[WORD_W-1];
        end
      end
      SHIFT: begin
        if (last_bit_c)       next_state = DONE;
        else if (word_last_c) next_state = LOAD;
        else                  head_d     = next_msb_c;
      end
      DONE:    next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  always_ff @(posedge prog_clk or negedge prog_rst_n) begin
    if (!prog_rst_n) begin
      state         <= IDLE;
      s_ready       <= 1'b0;
      ccff_head     <= 1'b0;
      ccff_shift_en <= 1'b0;
      busy          <= 1'b0;
      done          <= 1'b0;
      bit_cnt       <= '0;
    end else begin
      state         <= next_state;
      s_ready       <= (next_state == LOAD);
      ccff_head     <= head_d;
      ccff_shift_en <= (next_state == SHIFT);
      busy          <= (next_state == LOAD) || (next_state == SHIFT);
      done          <= (next_state == DONE);
      if ((state == IDLE) && start) bit_cnt <= '0;
      else if (shift_c)             bit_cnt <= bit_cnt + CNT_W'(1);
    end
  end

`ifdef CCFF_READBACK_EN
  localparam int unsigned RB_W = $clog2(WORD_W + 1);

  logic [WORD_W-1:0] rb_reg;
  logic [WORD_W-1:0] rb_next_c;
  logic [RB_W-1:0]   rb_cnt;
  logic              rb_flush_c;

  assign rb_next_c  = WORD_W'({rb_reg, ccff_tail});
  assign rb_flush_c = (rb_cnt == RB_W'(WORD_W - 1)) || last_bit_c;

  // Collect the displaced chain bits; a short final word is left-aligned.
  always_ff @(posedge prog_clk or negedge prog_rst_n) begin
    if (!prog_rst_n) begin
      rb_reg  <= '0;
      rb_cnt  <= '0;
      m_data  <= '0;
      m_valid <= 1'b0;
    end else begin
      m_valid <= 1'b0;
      if (shift_c) begin
        if (rb_flush_c) begin
          m_valid <= 1'b1;
          m_data  <= rb_next_c << (RB_W'(WORD_W - 1) - rb_cnt);
          rb_reg  <= '0;
          rb_cnt  <= '0;
        end else begin
          rb_reg  <= rb_next_c;
          rb_cnt  <= rb_cnt + RB_W'(1);
        end
      end
    end
  end
`endif

endmodule

// File: tb/tb_ccff_bitstream_loader.sv
// Directed bench: an 8/8 loader and a 12/8 loader, each feeding a model chain.
module tb_ccff_bitstream_loader;
  import ccff_loader_pkg::*;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  // Instance A: CHAIN_LEN=8, WORD_W=8
  logic       start_a = 1'b0, s_valid_a = 1'b0;
  logic [7:0] s_data_a = '0;
  logic       s_ready_a, head_a, sh_a, busy_a, done_a;
  logic       tail_a, m_valid_a;
  logic [7:0] m_data_a;

  // Instance B: CHAIN_LEN=12, WORD_W=8
  logic       start_b = 1'b0, s_valid_b = 1'b0;
  logic [7:0] s_data_b = '0;
  logic       s_ready_b, head_b, sh_b, busy_b, done_b;
  logic       tail_b, m_valid_b;
  logic [7:0] m_data_b;

  ccff_bitstream_loader #(.CHAIN_LEN(8), .WORD_W(8)) dut_a (
    .prog_clk      (clk),
    .prog_rst_n    (rst_n),
    .start         (start_a),
    .s_data        (s_data_a),
    .s_valid       (s_valid_a),
    .s_ready       (s_ready_a),
    .ccff_head     (head_a),
    .ccff_shift_en (sh_a),
    .busy          (busy_a),
    .done          (done_a)
`ifdef CCFF_READBACK_EN
    ,
    .ccff_tail     (tail_a),
    .m_data        (m_data_a),
    .m_valid       (m_valid_a)
`endif
  );

  ccff_bitstream_loader #(.CHAIN_LEN(12), .WORD_W(8)) dut_b (
    .prog_clk      (clk),
    .prog_rst_n    (rst_n),
    .start         (start_b),
    .s_data        (s_data_b),
    .s_valid       (s_valid_b),
    .s_ready       (s_ready_b),
    .ccff_head     (head_b),
    .ccff_shift_en (sh_b),
    .busy          (busy_b),
    .done          (done_b)
`ifdef CCFF_READBACK_EN
    ,
    .ccff_tail     (tail_b),
    .m_data        (m_data_b),
    .m_valid       (m_valid_b)
`endif
  );

`ifndef CCFF_READBACK_EN
  assign m_valid_a = 1'b0;
  assign m_data_a  = '0;
  assign m_valid_b = 1'b0;
  assign m_data_b  = '0;
`endif

  // Model chains and event counters
  logic [7:0]  chain_a = '0;
  logic [11:0] chain_b = '0;
  int shifts_a = 0, dones_a = 0, hs_a = 0, mv_a = 0;
  int shifts_b = 0, dones_b = 0, hs_b = 0;
  logic [7:0] md_a = '0;

  assign tail_a = chain_a[7];
  assign tail_b = chain_b[11];

  always @(posedge clk) begin
    if (sh_a) begin
      chain_a  <= {chain_a[6:0], head_a};
      shifts_a <= shifts_a + 1;
    end
    if (done_a) dones_a <= dones_a + 1;
    if (s_valid_a && s_ready_a) hs_a <= hs_a + 1;
    if (m_valid_a) begin
      mv_a <= mv_a + 1;
      md_a <= m_data_a;
    end
    if (sh_b) begin
      chain_b  <= {chain_b[10:0], head_b};
      shifts_b <= shifts_b + 1;
    end
    if (done_b) dones_b <= dones_b + 1;
    if (s_valid_b && s_ready_b) hs_b <= hs_b + 1;
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  // One load on A; optional extra start pulses during SHIFT and DONE.
  task automatic run_a(input logic [7:0] w, input bit extra_start,
                       output int cyc, output logic [7:0] hseq);
    int hs0;
    hs0  = hs_a;
    cyc  = -1;
    hseq = '0;
    @(negedge clk);
    start_a = 1'b1; s_valid_a = 1'b1; s_data_a = w;
    for (int i = 1; i <= int'(load_cycles(8, 8)) + 4; i++) begin
      @(negedge clk);
      if (sh_a) hseq = {hseq[6:0], head_a};
      if (done_a && cyc < 0) cyc = i;
      if (hs_a != hs0) s_valid_a = 1'b0;
      start_a = extra_start && (i == 4 || i == 10);
    end
    start_a = 1'b0;
    s_valid_a = 1'b0;
  endtask

  // Two-word load on B; optional s_valid stall before the second word.
  task automatic run_b(input logic [7:0] w0, input logic [7:0] w1, input int stall,
                       output int cyc);
    int hs0, left;
    logic [11:0] frozen;
    hs0 = hs_b;
    left = stall;
    cyc = -1;
    frozen = '0;
    @(negedge clk);
    start_b = 1'b1; s_valid_b = 1'b0;
    for (int i = 1; i <= 28; i++) begin
      @(negedge clk);
      start_b = 1'b0;
      if (done_b && cyc < 0) cyc = i;
      if ((hs_b - hs0) == 1 && s_ready_b && left > 0) begin
        if (left == stall) frozen = chain_b;
        else check_eq("stall_chain", 32'(chain_b), 32'(frozen));
        check_eq("stall_shift_en", 32'(sh_b), 32'd0);
        left--;
        s_valid_b = 1'b0;
      end else begin
        s_valid_b = ((hs_b - hs0) < 2);
        s_data_b  = ((hs_b - hs0) == 0) ? w0 : w1;
      end
    end
    s_valid_b = 1'b0;
  endtask

  initial begin : stim
    int cyc, s0, d0, h0;
    logic [7:0] hseq;

    // Reset state
    repeat (3) @(negedge clk);
    check_eq("rst_outputs_a", 32'({s_ready_a, head_a, sh_a, busy_a, done_a}), 32'd0);
    check_eq("rst_outputs_b", 32'({s_ready_b, head_b, sh_b, busy_b, done_b}), 32'd0);
    rst_n = 1'b1;
    @(negedge clk);
    check_eq("idle_outputs_a", 32'({s_ready_a, head_a, sh_a, busy_a, done_a}), 32'd0);

    // Single word 0xA5 on 8/8
    s0 = shifts_a; d0 = dones_a; h0 = hs_a;
    run_a(8'hA5, 1'b0, cyc, hseq);
    check_eq("a5_done_cycle", 32'(cyc), 32'd10);
    check_eq("a5_head_seq", 32'(hseq), 32'hA5);
    check_eq("a5_chain", 32'(chain_a), 32'hA5);
    check_eq("a5_shift_cnt", 32'(shifts_a - s0), 32'd8);
    check_eq("a5_done_cnt", 32'(dones_a - d0), 32'd1);
    check_eq("a5_handshakes", 32'(hs_a - h0), 32'd1);

    // Two words on 12/8: low nibble of the second word is dropped
    s0 = shifts_b; d0 = dones_b; h0 = hs_b;
    run_b(8'hF0, 8'h3C, 0, cyc);
    check_eq("b_done_cycle", 32'(cyc), 32'd15);
    check_eq("b_chain", 32'(chain_b), 32'hF03);
    check_eq("b_handshakes", 32'(hs_b - h0), 32'd2);
    check_eq("b_shift_cnt", 32'(shifts_b - s0), 32'd12);
    check_eq("b_done_cnt", 32'(dones_b - d0), 32'd1);

    // Same load with a 5-cycle stall between words; chain first disturbed by another pattern
    run_b(8'h0F, 8'hC0, 0, cyc);
    check_eq("b2_chain", 32'(chain_b), 32'h0FC);
    s0 = shifts_b; h0 = hs_b;
    run_b(8'hF0, 8'h3C, 5, cyc);
    check_eq("stall_done_cycle", 32'(cyc), 32'd20);
    check_eq("stall_chain_final", 32'(chain_b), 32'hF03);
    check_eq("stall_shift_cnt", 32'(shifts_b - s0), 32'd12);
    check_eq("stall_handshakes", 32'(hs_b - h0), 32'd2);

    // Async reset after 3 shifted bits
    s0 = shifts_a;
    @(negedge clk);
    start_a = 1'b1; s_valid_a = 1'b1; s_data_a = 8'h3C;
    for (int i = 0; i < 20 && (shifts_a - s0) < 3; i++) begin
      @(negedge clk);
      start_a = 1'b0;
    end
    check_eq("pre_rst_shifts", 32'(shifts_a - s0), 32'd3);
    check_eq("pre_rst_active", 32'({head_a, sh_a, busy_a}), 32'b111);
    rst_n = 1'b0;
    #1;
    check_eq("mid_rst_outputs", 32'({s_ready_a, head_a, sh_a, busy_a, done_a}), 32'd0);
    @(negedge clk);
    s_valid_a = 1'b0;
    rst_n = 1'b1;
    @(negedge clk);
    s0 = shifts_a;
    run_a(8'h96, 1'b0, cyc, hseq);
    check_eq("post_rst_cycle", 32'(cyc), 32'd10);
    check_eq("post_rst_chain", 32'(chain_a), 32'h96);
    check_eq("post_rst_shifts", 32'(shifts_a - s0), 32'd8);

    // start pulsed while busy and in DONE is ignored
    s0 = shifts_a; d0 = dones_a; h0 = hs_a;
    run_a(8'h4B, 1'b1, cyc, hseq);
    repeat (4) @(negedge clk);
    check_eq("busy_start_done_cnt", 32'(dones_a - d0), 32'd1);
    check_eq("busy_start_shifts", 32'(shifts_a - s0), 32'd8);
    check_eq("busy_start_hs", 32'(hs_a - h0), 32'd1);
    check_eq("busy_start_idle", 32'({busy_a, s_ready_a}), 32'd0);
    check_eq("busy_start_chain", 32'(chain_a), 32'h4B);

`ifdef CCFF_READBACK_EN
    // Readback returns the previous configuration
    run_a(8'h5A, 1'b0, cyc, hseq);
    check_eq("preload_chain", 32'(chain_a), 32'h5A);
    s0 = mv_a;
    run_a(8'hC3, 1'b0, cyc, hseq);
    check_eq("rb_mvalid_cnt", 32'(mv_a - s0), 32'd1);
    check_eq("rb_mdata", 32'(md_a), 32'h5A);
    check_eq("rb_new_chain", 32'(chain_a), 32'hC3);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
